// File: rtl/sd_adc_cic_if.sv
// Output handshake bundle of the sigma-delta ADC: sample, valid/ready, and overrun flag.
interface sd_adc_cic_if #(
    parameter int OUT_W = 12
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] dout;
    logic             overrun;

    modport master (output out_valid, output dout, output overrun, input out_ready);
    modport slave  (input out_valid, input dout, input overrun, output out_ready);
endinterface

// File: rtl/sd_adc_cic.sv
// First-order sigma-delta modulator feedback plus ORDER-stage CIC decimator with saturated output.
// Define SD_ADC_DCBLOCK_EN to insert a one-pole DC blocker after scaling (adds one clock of latency).
module sd_adc_cic #(
    parameter int ORDER      = 3,
    parameter int DECIM_LOG2 = 6,
    parameter int OUT_W      = 12,
    parameter int DC_SHIFT   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    input  logic            sdin,
    output logic            fb,
    output logic            newsample,
    sd_adc_cic_if.master    bus
);
    localparam int ACC_W  = ORDER * DECIM_LOG2 + 1;
    localparam int MSB    = ORDER * DECIM_LOG2;
    localparam int WARM_W = $clog2(ORDER + 1);

    logic                  fb_r;
    logic [DECIM_LOG2-1:0] cnt_r;
    logic [WARM_W-1:0]     warm_r;
    logic [ACC_W-1:0]      integ_r [ORDER];
    logic [ACC_W-1:0]      cdly_r  [ORDER];
    logic [ACC_W-1:0]      integ_s [ORDER];
    logic [ACC_W-1:0]      dly_in_s[ORDER];
    logic [ACC_W-1:0]      raw_s;
    logic [OUT_W-1:0]      s_s;
    logic                  tick_s;
    logic                  qual_s;
    logic                  load_s;
    logic [OUT_W-1:0]      load_dat_s;
    logic                  out_valid_r;
    logic [OUT_W-1:0]      dout_r;
    logic                  overrun_r;

    // Bit MSB can only be set by the full-scale value R^N, which is clipped to all ones.
    function automatic logic [OUT_W-1:0] scale(input logic [ACC_W-1:0] raw);
        logic [OUT_W-1:0] res;
        if (raw[MSB]) begin
            res = {OUT_W{1'b1}};
        end else begin
            res = raw[MSB-1 -: OUT_W];
        end
        return res;
    endfunction

    assign tick_s = ce & (&cnt_r);
    assign qual_s = tick_s & (warm_r == WARM_W'(ORDER));

    // Integrator chain (each stage fed by the next value of the previous one) and comb chain.
    always_comb begin
        logic [ACC_W-1:0] run;
        run = {{(ACC_W-1){1'b0}}, ~fb_r};
        for (int k = 0; k < ORDER; k++) begin
            run        = integ_r[k] + run;
            integ_s[k] = run;
        end
        for (int k = 0; k < ORDER; k++) begin
            dly_in_s[k] = run;
            run         = run - cdly_r[k];
        end
        raw_s = run;
        s_s   = scale(raw_s);
    end

    // Modulator feedback, integrators, decimation counter, comb delays and warm-up counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_r   <= 1'b0;
            cnt_r  <= '0;
            warm_r <= '0;
            for (int k = 0; k < ORDER; k++) begin
                integ_r[k] <= '0;
                cdly_r[k]  <= '0;
            end
        end else if (ce) begin
            fb_r  <= ~sdin;
            cnt_r <= cnt_r + DECIM_LOG2'(1);
            for (int k = 0; k < ORDER; k++) begin
                integ_r[k] <= integ_s[k];
            end
            if (tick_s) begin
                for (int k = 0; k < ORDER; k++) begin
                    cdly_r[k] <= dly_in_s[k];
                end
                if (warm_r != WARM_W'(ORDER)) begin
                    warm_r <= warm_r + WARM_W'(1);
                end
            end
        end
    end

`ifdef SD_ADC_DCBLOCK_EN
    logic [OUT_W+DC_SHIFT-1:0] dc_acc_r;
    logic [OUT_W-1:0]          dc_s_r;
    logic                      dc_pend_r;
    logic signed [OUT_W+1:0]   dc_y_s;
    logic [OUT_W-1:0]          dc_out_s;

    // Blocker stage: hold the scaled sample one clock, then update the DC estimate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dc_acc_r  <= '0;
            dc_s_r    <= '0;
            dc_pend_r <= 1'b0;
        end else begin
            dc_pend_r <= qual_s;
            if (qual_s) begin
                dc_s_r <= s_s;
            end
            if (dc_pend_r) begin
                dc_acc_r <= dc_acc_r + {{DC_SHIFT{1'b0}}, dc_s_r} - (dc_acc_r >> DC_SHIFT);
            end
        end
    end

    // Remove the DC estimate, re-centre on mid-scale and clamp to the unsigned range.
    always_comb begin
        dc_y_s = $signed({2'b00, dc_s_r})
               - $signed({2'b00, dc_acc_r[OUT_W+DC_SHIFT-1:DC_SHIFT]})
               + $signed({2'b01, {OUT_W{1'b0}}} >> 1);
        if (dc_y_s < $signed({(OUT_W+2){1'b0}})) begin
            dc_out_s = '0;
        end else if (dc_y_s > $signed({2'b00, {OUT_W{1'b1}}})) begin
            dc_out_s = {OUT_W{1'b1}};
        end else begin
            dc_out_s = dc_y_s[OUT_W-1:0];
        end
    end

    assign load_s     = dc_pend_r;
    assign load_dat_s = dc_out_s;
`else
    assign load_s     = qual_s;
    assign load_dat_s = s_s;
`endif

    // Output register: a new sample always wins; overwriting an unconsumed one flags overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            dout_r      <= '0;
            overrun_r   <= 1'b0;
        end else if (load_s) begin
            dout_r      <= load_dat_s;
            out_valid_r <= 1'b1;
            overrun_r   <= out_valid_r & ~bus.out_ready;
        end else begin
            overrun_r <= 1'b0;
            if (out_valid_r & bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign fb            = fb_r;
    assign newsample     = tick_s;
    assign bus.out_valid = out_valid_r;
    assign bus.dout      = dout_r;
    assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_sd_adc_cic.sv
// Scoreboard bench for sd_adc_cic at default parameters (DC blocker disabled).
module tb_sd_adc_cic;
    typedef struct {
        int         cyc;
        logic [11:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b0;
    logic sdin = 1'b0;
    logic fb;
    logic newsample;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ns_prev = -1;
    int   ns_first = 63;
    int   ns_period = 64;
    exp_t sb[$];

    sd_adc_cic_if #(.OUT_W(12)) bus ();

    sd_adc_cic dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .sdin      (sdin),
        .fb        (fb),
        .newsample (newsample),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Cycle index since the last reset release: cycle k lies after k rising edges.
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_phase(input logic c, input logic d, input logic r, input int first, input int per);
        reset = 1'b1;
        ce = c;
        sdin = d;
        bus.out_ready = r;
        ns_first = first;
        ns_period = per;
        step(2);
        reset = 1'b0;
    endtask

    // Monitor: every accepted sample must match the head of the scoreboard in value and time.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_sample", bus.dout, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dout", bus.dout, e.val);
                chk("sample_cycle", cyc, e.cyc);
            end
        end
    end

    // newsample timing: first pulse after reset and spacing between pulses.
    always @(negedge clk) begin
        if (reset) begin
            ns_prev = -1;
        end else if (newsample) begin
            if (ns_prev < 0) begin
                chk("newsample_first", cyc, ns_first);
            end else if (ns_period != 0) begin
                chk("newsample_period", cyc - ns_prev, ns_period);
            end
            ns_prev = cyc;
        end
    end

    initial begin
        logic seen;
        bus.out_ready = 1'b0;
        step(3);
        chk("rst_fb", fb, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_newsample", newsample, 0);

        // sdin stuck high: full scale after three suppressed ticks
        begin_phase(1'b1, 1'b1, 1'b1, 63, 64);
        for (int i = 0; i < 4; i++) sb.push_back('{cyc: 256 + 64 * i, val: 12'hFFF});
        step(479);
        chk("fb_sdin1", fb, 0);
        chk("sb_empty_p1", sb.size(), 0);

        // sdin stuck low: zero output, feedback held high
        begin_phase(1'b1, 1'b0, 1'b1, 63, 64);
        for (int i = 0; i < 4; i++) sb.push_back('{cyc: 256 + 64 * i, val: 12'h000});
        step(479);
        chk("fb_sdin0", fb, 1);
        chk("sb_empty_p2", sb.size(), 0);

        // alternating bit stream: exactly mid-scale
        begin_phase(1'b1, 1'b1, 1'b1, 63, 64);
        for (int i = 0; i < 4; i++) sb.push_back('{cyc: 256 + 64 * i, val: 12'h800});
        for (int c = 1; c < 480; c++) begin
            step(1);
            sdin = ~sdin;
        end
        chk("sb_empty_p3", sb.size(), 0);

        // back-pressure across two ticks, then accept, then async reset with a pending sample
        begin_phase(1'b1, 1'b1, 1'b0, 63, 64);
        step(256);
        chk("hs_first_valid", bus.out_valid, 1);
        chk("hs_first_no_overrun", bus.overrun, 0);
        step(64);
        chk("hs_overrun", bus.overrun, 1);
        chk("hs_valid_held", bus.out_valid, 1);
        chk("hs_dout_second", bus.dout, 12'hFFF);
        step(1);
        chk("hs_overrun_pulse", bus.overrun, 0);
        sb.push_back('{cyc: 321, val: 12'hFFF});
        bus.out_ready = 1'b1;
        step(1);
        chk("hs_valid_drop", bus.out_valid, 0);
        bus.out_ready = 1'b0;
        step(78);
        chk("hs_pending", bus.out_valid, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_dout", bus.dout, 0);
        chk("sb_empty_p4", sb.size(), 0);

        // ce every other clock, then frozen for 100 clocks, then continuous
        begin_phase(1'b1, 1'b1, 1'b1, 126, 128);
        sb.push_back('{cyc: 511, val: 12'hFFF});
        sb.push_back('{cyc: 639, val: 12'hFFF});
        sb.push_back('{cyc: 814, val: 12'hFFF});
        for (int c = 1; c < 660; c++) begin
            step(1);
            ce = ~ce;
            if (c == 512) chk("accept_ce_low", bus.out_valid, 0);
        end
        step(1);
        ce = 1'b0;
        ns_period = 0;
        seen = 1'b0;
        for (int c = 660; c < 760; c++) begin
            if (c > 660) step(1);
            seen = seen | newsample;
        end
        chk("freeze_newsample", seen, 0);
        chk("freeze_dout", bus.dout, 12'hFFF);
        chk("freeze_fb", fb, 0);
        step(1);
        ce = 1'b1;
        step(90);
        chk("sb_empty_p5", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
